// File: rtl/conv_mxfp6tobf16_if.sv
// Block-in / beat-out bus for the MXFP6 to BF16 decoder.
// Valid/ready on both sides: a transfer happens on any clock edge where valid && ready.
interface conv_mxfp6tobf16_if #(
    parameter int bit_width = 6,
    parameter int k         = 32,
    parameter int lanes     = 8,
    parameter int beat_w    = 2
);
    logic                    i_valid;
    logic                    o_ready;
    logic [bit_width*k-1:0]  i_mx_vec;
    logic [7:0]              i_mx_exp;
    logic                    o_valid;
    logic                    i_ready;
    logic [16*lanes-1:0]     o_bf16_vec;
    logic [beat_w-1:0]       o_beat;
    logic                    o_last;

    modport master (
        output i_valid, i_mx_vec, i_mx_exp, i_ready,
        input  o_ready, o_valid, o_bf16_vec, o_beat, o_last
    );

    modport slave (
        input  i_valid, i_mx_vec, i_mx_exp, i_ready,
        output o_ready, o_valid, o_bf16_vec, o_beat, o_last
    );
endinterface

// File: rtl/conv_mxfp6tobf16.sv
// Decodes one MXFP6 block (k elements + shared E8M0 scale) into BF16,
// streaming lanes elements per beat. Valid/ready: transfer when valid && ready.
module conv_mxfp6tobf16 #(
    parameter int exp_width = 3,
    parameter int man_width = 2,
    parameter int k         = 32,
    parameter int lanes     = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    conv_mxfp6tobf16_if.slave       bus,
    output logic                    o_dbg_state
);
    localparam int bit_width = 1 + exp_width + man_width;
    localparam int beats     = k / lanes;
    localparam int beat_w    = (beats > 1) ? $clog2(beats) : 1;
    localparam int bias      = (1 << (exp_width - 1)) - 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [bit_width*k-1:0]  vec_q, vec_d;
    logic [7:0]              scale_q, scale_d;
    logic                    valid_q, valid_d;
    logic [beat_w-1:0]       beat_q, beat_d;
    logic                    last_q, last_d;
    logic [16*lanes-1:0]     bf16_q, bf16_d;

    logic                    accept;
    logic                    fire_out;
    logic                    ready;
    logic [bit_width*k-1:0]  src_vec;
    logic [7:0]              src_scale;
    logic [beat_w-1:0]       src_beat;
    logic                    src_last;
    int                      slice_base;
    logic [16*lanes-1:0]     slice_dec;

    // Exact decode of one element; the unbiased exponent range fits easily in int.
    function automatic logic [15:0] decode_elem(input logic [bit_width-1:0] el,
                                                input logic [7:0] x);
        logic                   s;
        logic [exp_width-1:0]   e;
        logic [man_width-1:0]   m;
        logic [6:0]             mant;
        logic [man_width+6:0]   sh;
        int                     p;
        int                     ev;
        s    = el[bit_width-1];
        e    = el[man_width +: exp_width];
        m    = el[man_width-1:0];
        mant = '0;
        sh   = '0;
        p    = 0;
        ev   = 0;
        if (x == 8'hFF) return 16'h7FC0;
        if (e == '0 && m == '0) return {s, 15'h0};
        if (e != '0) begin
            ev = int'(x) + int'(e) - bias;
            mant[6 -: man_width] = m;
        end else begin
            for (int i = 0; i < man_width; i++) begin
                if (m[i]) p = i;
            end
            ev   = int'(x) + 1 - bias - (man_width - p);
            // Shift the leading one out; the remaining fraction bits become the mantissa.
            sh   = {m, 7'h0} << (man_width - p);
            mant = sh[man_width+6 -: 7];
        end
        if (ev >= 255) return {s, 8'hFF, 7'h0};
        if (ev <= 0) return {s, 15'h0};
        return {s, ev[7:0], mant};
    endfunction

    assign fire_out = valid_q && bus.i_ready;
    assign accept   = bus.i_valid && ready;

    // Source for the next output beat: the incoming block on accept, else the latched one.
    always_comb begin
        src_vec   = vec_q;
        src_scale = scale_q;
        src_beat  = beat_q + beat_w'(1);
        if (accept) begin
            src_vec   = bus.i_mx_vec;
            src_scale = bus.i_mx_exp;
            src_beat  = '0;
        end
        src_last   = (src_beat == beat_w'(beats - 1));
        slice_base = (int'(src_beat) % beats) * lanes;
    end

    always_comb begin
        slice_dec = '0;
        for (int l = 0; l < lanes; l++) begin
            slice_dec[l*16 +: 16] = decode_elem(src_vec[(slice_base + l)*bit_width +: bit_width],
                                                src_scale);
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (fire_out && last_q && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready       = (state_q == IDLE) || (fire_out && last_q);
        o_dbg_state = (state_q == SEND);
    end

    always_comb begin
        vec_d   = vec_q;
        scale_d = scale_q;
        valid_d = valid_q;
        beat_d  = beat_q;
        last_d  = last_q;
        bf16_d  = bf16_q;
        if (accept) begin
            vec_d   = bus.i_mx_vec;
            scale_d = bus.i_mx_exp;
            valid_d = 1'b1;
            beat_d  = src_beat;
            last_d  = src_last;
            bf16_d  = slice_dec;
        end else if (fire_out) begin
            if (last_q) begin
                valid_d = 1'b0;
                beat_d  = '0;
                last_d  = 1'b0;
            end else begin
                beat_d  = src_beat;
                last_d  = src_last;
                bf16_d  = slice_dec;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vec_q   <= '0;
            scale_q <= '0;
            valid_q <= 1'b0;
            beat_q  <= '0;
            last_q  <= 1'b0;
            bf16_q  <= '0;
        end else begin
            vec_q   <= vec_d;
            scale_q <= scale_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            bf16_q  <= bf16_d;
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid_q;
    assign bus.o_bf16_vec = bf16_q;
    assign bus.o_beat     = beat_q;
    assign bus.o_last     = last_q;
endmodule

// File: tb/tb_conv_mxfp6tobf16.sv
// Bench for conv_mxfp6tobf16: value-level reference model, per-cycle beat scoreboard,
// directed literal cases, backpressure, back-to-back, mid-block reset and random traffic.
module tb_conv_mxfp6tobf16;
    localparam int K     = 32;
    localparam int LANES = 8;
    localparam int BEATS = K / LANES;

    logic clk = 1'b0;
    logic rst;
    logic dbg_state;
    logic rand_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [130:0] exp_q[$];

    conv_mxfp6tobf16_if #(.bit_width(6), .k(K), .lanes(LANES), .beat_w(2)) bus ();

    conv_mxfp6tobf16 #(.exp_width(3), .man_width(2), .k(K), .lanes(LANES)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [130:0] act, input logic [130:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value = sig * 2^pw with a small integer significand, then renormalised into BF16.
    function automatic logic [15:0] model_elem(input logic [5:0] el, input logic [7:0] x);
        logic s;
        int   e, m, sig, pw, q, be, frac;
        s = el[5];
        e = int'(el[4:2]);
        m = int'(el[1:0]);
        if (x == 8'hFF) return 16'h7FC0;
        if (e != 0) begin
            sig = 4 + m;
            pw  = e - 5;
        end else begin
            sig = m;
            pw  = -4;
        end
        if (sig == 0) return {s, 15'h0};
        pw   = pw + int'(x) - 127;
        q    = (sig >= 4) ? 2 : (sig >= 2) ? 1 : 0;
        be   = pw + q + 127;
        if (be >= 255) return {s, 8'hFF, 7'h0};
        if (be <= 0) return {s, 15'h0};
        frac = (sig - (1 << q)) << (7 - q);
        return {s, be[7:0], frac[6:0]};
    endfunction

    function automatic logic [127:0] model_beat(input logic [191:0] vec, input logic [7:0] x,
                                                input int b);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*16 +: 16] = model_elem(vec[(b*LANES + l)*6 +: 6], x);
        return r;
    endfunction

    function automatic logic [191:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: sampled at negedge, when inputs and outputs are both settled.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("o_valid", bus.o_valid, exp_q.size() != 0);
            check("o_ready", bus.o_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && bus.i_ready));
            check("dbg_state", dbg_state, exp_q.size() != 0);
            if (bus.o_valid && exp_q.size() != 0)
                check("beat", {bus.o_last, bus.o_beat, bus.o_bf16_vec}, exp_q[0]);
            if (bus.o_valid && bus.i_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (bus.i_valid && bus.o_ready) begin
                for (int b = 0; b < BEATS; b++)
                    exp_q.push_back({(b == BEATS - 1) ? 1'b1 : 1'b0, 2'(b),
                                     model_beat(bus.i_mx_vec, bus.i_mx_exp, b)});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 bus.i_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_block(input logic [191:0] vec, input logic [7:0] x, input bit hold_valid);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.i_valid  = 1'b1;
        bus.i_mx_vec = vec;
        bus.i_mx_exp = x;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = bus.o_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_timeout", acc, 1'b1);
        if (!hold_valid) begin
            bus.i_valid  = 1'b0;
            bus.i_mx_vec = rand_vec();
            bus.i_mx_exp = 8'($urandom());
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.o_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", bus.o_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_beat0(input logic [191:0] vec, input logic [7:0] x,
                             output logic [127:0] beat0);
        send_block(vec, x, 1'b0);
        @(negedge clk);
        beat0 = bus.o_bf16_vec;
        check("beat0_index", bus.o_beat, 2'd0);
        drain();
    endtask

    initial begin
        logic [191:0] v, v2;
        logic [127:0] b0;
        logic [7:0]   x;
        int           n, retire, acc_at;
        bit           hold;

        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b1;
        bus.i_mx_vec = '0;
        bus.i_mx_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_o_valid", bus.o_valid, 1'b0);
        check("rst_o_ready", bus.o_ready, 1'b1);
        check("rst_o_beat", bus.o_beat, 2'd0);
        check("rst_o_last", bus.o_last, 1'b0);
        check("rst_o_bf16", bus.o_bf16_vec, 128'h0);
        @(posedge clk);
        #1;

        check("pin_28", model_elem(6'b0_111_11, 8'd127), 16'h41E0);
        check("pin_m1", model_elem(6'b1_011_00, 8'd127), 16'hBF80);
        check("pin_sub2", model_elem(6'b0_000_10, 8'd127), 16'h3E00);
        check("pin_sub1", model_elem(6'b0_000_01, 8'd127), 16'h3D80);
        check("pin_sub3", model_elem(6'b1_000_11, 8'd127), 16'hBE40);
        check("pin_inf", model_elem(6'b0_111_00, 8'd254), 16'h7F80);
        check("pin_flush", model_elem(6'b1_001_00, 8'd1), 16'h8000);
        check("pin_nan", model_elem(6'b1_101_10, 8'hFF), 16'h7FC0);

        // Normal, zero and subnormal elements at unit scale
        v = rand_vec();
        v[0*6 +: 6] = 6'b0_111_11;
        v[1*6 +: 6] = 6'b1_011_00;
        v[2*6 +: 6] = 6'b0_000_00;
        v[3*6 +: 6] = 6'b1_000_00;
        v[4*6 +: 6] = 6'b0_000_10;
        v[5*6 +: 6] = 6'b0_000_01;
        v[6*6 +: 6] = 6'b1_000_11;
        run_beat0(v, 8'd127, b0);
        check("dir_28", b0[0*16 +: 16], 16'h41E0);
        check("dir_m1", b0[1*16 +: 16], 16'hBF80);
        check("dir_zero", b0[2*16 +: 16], 16'h0000);
        check("dir_negzero", b0[3*16 +: 16], 16'h8000);
        check("dir_sub2", b0[4*16 +: 16], 16'h3E00);
        check("dir_sub1", b0[5*16 +: 16], 16'h3D80);
        check("dir_sub3", b0[6*16 +: 16], 16'hBE40);

        v = rand_vec();
        v[0*6 +: 6] = 6'b0_111_00;
        v[1*6 +: 6] = 6'b1_111_00;
        run_beat0(v, 8'd254, b0);
        check("dir_inf", b0[0*16 +: 16], 16'h7F80);
        check("dir_ninf", b0[1*16 +: 16], 16'hFF80);

        v = rand_vec();
        v[0*6 +: 6] = 6'b0_001_00;
        v[1*6 +: 6] = 6'b1_001_00;
        run_beat0(v, 8'd1, b0);
        check("dir_flush_p", b0[0*16 +: 16], 16'h0000);
        check("dir_flush_n", b0[1*16 +: 16], 16'h8000);

        run_beat0(rand_vec(), 8'hFF, b0);
        check("dir_nan_all", b0, {LANES{16'h7FC0}});

        // Backpressure on beat 1
        for (int i = 0; i < K; i++) v[i*6 +: 6] = 6'(6'b0_011_00 + i);
        send_block(v, 8'd127, 1'b0);
        @(posedge clk);
        #1 bus.i_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_beat", bus.o_beat, 2'd1);
            check("bp_data", bus.o_bf16_vec, model_beat(v, 8'd127, 1));
            check("bp_ready", bus.o_ready, 1'b0);
        end
        @(posedge clk);
        #1 bus.i_ready = 1'b1;
        drain();

        // Back-to-back blocks with i_valid held
        v  = rand_vec();
        v2 = rand_vec();
        send_block(v, 8'd127, 1'b1);
        bus.i_mx_vec = v2;
        bus.i_mx_exp = 8'd120;
        retire = 0;
        acc_at = -1;
        for (int c = 0; c < 2 * BEATS; c++) begin
            @(negedge clk);
            if (bus.o_valid && bus.i_ready) retire++;
            if (bus.i_valid && bus.o_ready) acc_at = c;
            @(posedge clk);
            #1;
            if (acc_at == c) bus.i_valid = 1'b0;
        end
        bus.i_valid = 1'b0;
        check("b2b_retired", retire, 8);
        check("b2b_accept_cycle", acc_at, BEATS - 1);
        drain();

        // Reset during beat 2
        v = rand_vec();
        send_block(v, 8'd130, 1'b0);
        n = 0;
        @(negedge clk);
        while (bus.o_beat != 2'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_beat1", bus.o_beat, 2'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_beat2", bus.o_beat, 2'd2);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", bus.o_valid, 1'b0);
        check("rst_mid_ready", bus.o_ready, 1'b1);
        @(posedge clk);
        #1;
        v = rand_vec();
        run_beat0(v, 8'd127, b0);
        check("rst_new_beat0", b0, model_beat(v, 8'd127, 0));

        // Random traffic with random downstream stalls
        @(posedge clk);
        #1 rand_ready = 1'b1;
        for (int blk = 0; blk < 60; blk++) begin
            case ($urandom_range(0, 9))
                0:       x = 8'hFF;
                1:       x = 8'd254;
                2:       x = 8'd1;
                3:       x = 8'd0;
                4:       x = 8'($urandom_range(120, 134));
                default: x = 8'($urandom());
            endcase
            hold = ($urandom_range(0, 2) == 0);
            send_block(rand_vec(), x, hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        bus.i_valid = 1'b0;
        rand_ready  = 1'b0;
        @(posedge clk);
        #2 bus.i_ready = 1'b1;
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_mxfp6tobf16.md
Name: conv_mxfp6tobf16

Overview:
Decodes one MXFP6 block (k elements plus a shared 8-bit E8M0 scale) back to BF16. It is the inverse of the BF16-to-MXFP6 encoder and sits on the read side of MX storage or links. A block is accepted in one beat through a valid/ready handshake, latched, and streamed out as k/lanes BF16 beats through a second valid/ready handshake.

Parameters:
exp_width, 3, element exponent bits; element bias = 2^(exp_width-1)-1 (3 for E3M2)
man_width, 2, element mantissa bits
bit_width, 1+exp_width+man_width, element width (derived)
k, 32, elements per block
lanes, 8, BF16 elements per output beat; k % lanes == 0 and k/lanes >= 1
beats, k/lanes, output beats per block (derived)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  input block valid
o_ready  output  1  block accepted when i_valid && o_ready
i_mx_vec  input  bit_width x k  elements {sgn, exp, man}
i_mx_exp  input  8  shared E8M0 scale X
o_valid  output  1  output beat valid
i_ready  input  1  downstream accepts beat when o_valid && i_ready
o_bf16_vec  output  16 x lanes  BF16 results for elements [beat*lanes +: lanes]
o_beat  output  $clog2(beats) (min 1)  index of the current beat
o_last  output  1  current beat is beat beats-1

Behaviour:
- Element decode, where s = sign, e = exp field, m = man field, X = scale:
  - X == 8'hFF: 16'h7FC0 for every element, sign ignored.
  - e == 0 && m == 0: {s, 15'h0}.
  - Normal (e != 0): unbiased E = X + e - bias; mantissa = {m, zeros} left-aligned to 7 bits.
  - Subnormal (e == 0, m != 0): locate leading one at bit position p of m (0 = LSB). E = X + 1 - bias - (man_width - p). Mantissa = bits of m below p, left-aligned to 7 bits.
  - E computed signed, 10 bits wide. E >= 255 gives {s, 8'hFF, 7'h0} (Inf). E <= 0 gives {s, 15'h0}; BF16 subnormals are never produced (flush). Otherwise {s, E[7:0], mant}.
  - Results are exact; no rounding is needed.
- FSM states:
  - IDLE: no block held.
  - SEND: block latched, beats in flight.
- Handshake:
  - o_ready = (state == IDLE) || (o_valid && i_ready && o_last). A back-to-back block is therefore taken in the cycle the final beat retires.
  - On accept in cycle T, the whole input vector and X are registered, and beat 0 appears with o_valid = 1 in cycle T+1.
  - The output beat register (o_bf16_vec, o_beat, o_last, o_valid) is registered; the decode of the selected slice happens between the latch and this register.
  - While o_valid && !i_ready: o_bf16_vec, o_beat and o_last hold stable.
  - On o_valid && i_ready: advance to the next beat the following cycle. After the last beat, go to IDLE (o_valid = 0), or load beat 0 of the block accepted in the same cycle.
  - No bubbles between beats when i_ready stays high. Throughput is one block per beats cycles.
  - Changes on i_mx_vec while in SEND have no effect.
- beats == 1: o_last is constantly 1 while valid; one block per cycle at full throughput.
- Reset (sync, i_rst = 1 at the clock edge):
  - o_valid = 0, o_beat = 0, o_last = 0, o_bf16_vec = all 0, state = IDLE. o_ready = 1 from the first cycle after reset.
  - A block in flight is discarded with no partial beats after reset.
  - i_rst has priority over a simultaneous handshake.

Test Plan:
- Normal decode: X = 127, elem0 = 6'b0_111_11, elem1 = 6'b1_011_00 -> beat 0 lanes 0/1 = 16'h41E0 (28.0) / 16'hBF80 (-1.0). Zero elements -> 16'h0000; 6'b1_000_00 -> 16'h8000.
- Subnormals: X = 127, 6'b0_000_10 -> 16'h3E00 (0.125); 6'b0_000_01 -> 16'h3D80 (0.0625); 6'b1_000_11 -> 16'hBE40 (-0.1875).
- Range and special scales:
  - X = 254, e = 7 -> 16'h7F80 (negative input -> 16'hFF80).
  - X = 1, e = 1 -> signed zero.
  - X = 8'hFF -> all lanes 16'h7FC0 for any element values.
- Streaming and backpressure, k = 32, lanes = 8, element i = 6'b0_011_00 + i:
  - Keep i_ready low 3 cycles on beat 1 -> beat 1 stable, o_beat = 1.
  - Then 4 beats total, o_last only on beat 3, o_ready low throughout SEND except on the final-beat accept.
- Back-to-back blocks with i_ready = 1 and i_valid held high: the second block is accepted on the cycle beat 3 of the first retires. Beat 0 of block 2 follows with no idle cycle; 8 beats in 8 consecutive cycles.
- Reset mid-block: assert i_rst during beat 2 -> next cycle o_valid = 0 and o_ready = 1. A new block then starts at beat 0 with correct data.
